// File: rtl/phy_tx_pkg.sv
// +-------------------------------------------------------------------+
// | phy_tx_pkg : shared modes, lane FSM states and LFSR step function |
// | Rev 1.0                                                           |
// +-------------------------------------------------------------------+
`default_nettype none

package phy_tx_pkg;

  localparam logic [1:0] MODE_INC   = 2'd0;
  localparam logic [1:0] MODE_CONST = 2'd1;
  localparam logic [1:0] MODE_LFSR  = 2'd2;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_OFFSET = 2'd1,
    ST_BURST  = 2'd2,
    ST_GAP    = 2'd3
  } lane_state_e;

  // Right-shifting Galois step; the mask holds the tap positions minus one.
  function automatic logic [31:0] lfsr_next(input logic [31:0] data, input int width);
    logic [31:0] mask;
    logic [31:0] res;
    case (width)
      16:      mask = 32'h0000_D008;
      32:      mask = 32'h8020_0003;
      default: mask = 32'h0000_00B8;
    endcase
    res = data >> 1;
    if (data[0]) res = res ^ mask;
    return res;
  endfunction

endpackage

`default_nettype wire

// File: rtl/phy_tx_pattern_gen_lane_seq.sv
// +-------------------------------------------------------------------+
// | lane_seq : one lane's offset/burst/gap FSM, payload and word count |
// | Rev 1.0                                                           |
// +-------------------------------------------------------------------+
`default_nettype none

module lane_seq
  import phy_tx_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int CNT_W  = 8
) (
  input  logic              clk_8f,
  input  logic              reset_L,
  input  logic              i_adv,
  input  logic              i_enable,
  input  logic [1:0]        i_mode,
  input  logic [CNT_W-1:0]  i_burst_len,
  input  logic [CNT_W-1:0]  i_gap_len,
  input  logic [CNT_W-1:0]  i_lane_ofs,
  input  logic [DATA_W-1:0] i_seed,
  output logic              o_valid,
  output logic [DATA_W-1:0] o_data,
  output logic [15:0]       o_word_cnt
);

  localparam logic [CNT_W-1:0]  c_CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [DATA_W-1:0] c_DATA_ONE = {{(DATA_W-1){1'b0}}, 1'b1};

  lane_state_e       r_state;
  logic [CNT_W-1:0]  r_rem;
  logic [1:0]        r_mode;
  logic [CNT_W-1:0]  r_burst;
  logic [CNT_W-1:0]  r_gap;
  logic [DATA_W-1:0] r_seed;
  logic [DATA_W-1:0] r_data;
  logic              r_valid;
  logic [15:0]       r_wcnt;

  logic              w_first;
  logic [1:0]        w_mode;
  logic [CNT_W-1:0]  w_burst;
  logic [CNT_W-1:0]  w_gap;
  logic [DATA_W-1:0] w_seed;
  lane_state_e       w_st;
  logic [CNT_W-1:0]  w_rem;
  logic [CNT_W-1:0]  w_rem_nxt;
  logic              w_valid;
  logic [DATA_W-1:0] w_base;
  logic [DATA_W-1:0] w_lfsr;
  logic [DATA_W-1:0] w_step;
  logic [DATA_W-1:0] w_data_nxt;

  // On the very first slot the live config inputs stand in for the not-yet-latched copies.
  always_comb begin
    w_first = (r_state == ST_IDLE);
    w_mode  = w_first ? i_mode      : r_mode;
    w_burst = w_first ? i_burst_len : r_burst;
    w_gap   = w_first ? i_gap_len   : r_gap;
    w_seed  = w_first ? i_seed      : r_seed;
    w_st    = w_first ? ST_OFFSET   : r_state;
    w_rem   = w_first ? i_lane_ofs  : r_rem;

    // Exhausted phases hand over within the same slot; burst 0 parks the lane in GAP.
    if (w_st == ST_OFFSET && w_rem == '0) begin
      w_st  = ST_BURST;
      w_rem = w_burst;
    end
    if (w_st == ST_BURST && w_rem == '0) begin
      w_st  = ST_GAP;
      w_rem = w_gap;
    end
    if (w_st == ST_GAP && w_rem == '0 && w_burst != '0) begin
      w_st  = ST_BURST;
      w_rem = w_burst;
    end

    w_valid   = (w_st == ST_BURST);
    w_rem_nxt = (w_rem != '0) ? (w_rem - c_CNT_ONE) : w_rem;

    if (w_first) begin
      w_base = (w_mode == MODE_LFSR && i_seed == '0) ? c_DATA_ONE : i_seed;
    end else begin
      w_base = r_data;
    end

    w_lfsr = DATA_W'(lfsr_next(32'(w_base), DATA_W));
    case (w_mode)
      MODE_CONST: w_step = w_seed;
      MODE_LFSR:  w_step = w_lfsr;
      default:    w_step = w_base + c_DATA_ONE;
    endcase
    w_data_nxt = w_valid ? w_step : w_base;
  end

  always_ff @(posedge clk_8f or negedge reset_L) begin
    if (!reset_L) begin
      r_state <= ST_IDLE;
      r_rem   <= '0;
      r_mode  <= '0;
      r_burst <= '0;
      r_gap   <= '0;
      r_seed  <= '0;
      r_data  <= '0;
      r_valid <= 1'b0;
      r_wcnt  <= '0;
    end else if (i_adv) begin
      if (w_first) begin
        r_mode  <= i_mode;
        r_burst <= i_burst_len;
        r_gap   <= i_gap_len;
        r_seed  <= i_seed;
      end
      r_state <= w_st;
      r_rem   <= w_rem_nxt;
      r_data  <= w_data_nxt;
      r_valid <= w_valid;
      if (w_valid && r_wcnt != 16'hFFFF) r_wcnt <= r_wcnt + 16'd1;
    end else if (!i_enable) begin
      r_valid <= 1'b0;
    end
  end

  assign o_valid    = r_valid;
  assign o_data     = r_data;
  assign o_word_cnt = r_wcnt;

endmodule

`default_nettype wire

// File: rtl/phy_tx_pattern_gen.sv
// +-------------------------------------------------------------------+
// | phy_tx_pattern_gen : multi-lane slotted traffic source for phy_tx |
// | Rev 1.0                                                           |
// +-------------------------------------------------------------------+
`default_nettype none

module phy_tx_pattern_gen
  import phy_tx_pkg::*;
#(
  parameter int LANES  = 2,
  parameter int DATA_W = 8,
  parameter int DIV    = 4,
  parameter int CNT_W  = 8
) (
  input  logic                    clk_8f,
  input  logic                    reset_L,
  input  logic                    enable,
  input  logic [1:0]              mode,
  input  logic [CNT_W-1:0]        burst_len,
  input  logic [CNT_W-1:0]        gap_len,
  input  logic [LANES*CNT_W-1:0]  lane_ofs,
  input  logic [LANES*DATA_W-1:0] seed,
  output logic                    slot_stb,
  output logic [LANES-1:0]        valid_data,
  output logic [LANES*DATA_W-1:0] data_in,
  output logic [LANES*16-1:0]     word_cnt
);

  localparam int c_CW = (DIV > 2) ? $clog2(DIV) : 1;
  localparam logic [c_CW-1:0] c_LAST = c_CW'(DIV - 1);
  localparam logic [c_CW-1:0] c_PRE  = c_CW'(DIV - 2);

  logic [c_CW-1:0] r_slot_cnt;
  logic            r_slot_stb;
  logic            w_adv;

  // The strobe is registered one count early so it is high while the counter sits at DIV-1.
  always_ff @(posedge clk_8f or negedge reset_L) begin
    if (!reset_L) begin
      r_slot_cnt <= '0;
      r_slot_stb <= 1'b0;
    end else if (enable) begin
      r_slot_cnt <= (r_slot_cnt == c_LAST) ? '0 : r_slot_cnt + c_CW'(1);
      r_slot_stb <= (r_slot_cnt == c_PRE);
    end else begin
      r_slot_stb <= 1'b0;
    end
  end

  assign w_adv    = r_slot_stb & enable;
  assign slot_stb = r_slot_stb;

  generate
    for (genvar gi = 0; gi < LANES; gi++) begin : g_lanes
      lane_seq #(
        .DATA_W (DATA_W),
        .CNT_W  (CNT_W)
      ) u_lane (
        .clk_8f      (clk_8f),
        .reset_L     (reset_L),
        .i_adv       (w_adv),
        .i_enable    (enable),
        .i_mode      (mode),
        .i_burst_len (burst_len),
        .i_gap_len   (gap_len),
        .i_lane_ofs  (lane_ofs[gi*CNT_W +: CNT_W]),
        .i_seed      (seed[gi*DATA_W +: DATA_W]),
        .o_valid     (valid_data[gi]),
        .o_data      (data_in[gi*DATA_W +: DATA_W]),
        .o_word_cnt  (word_cnt[gi*16 +: 16])
      );
    end
  endgenerate

endmodule

`default_nettype wire

// File: tb/tb_phy_tx_pattern_gen.sv
// +-------------------------------------------------------------------+
// | tb_phy_tx_pattern_gen : scoreboard bench with slot-level model    |
// | Rev 1.0                                                           |
// +-------------------------------------------------------------------+
`default_nettype none

module tb_phy_tx_pattern_gen;

  localparam int LANES  = 2;
  localparam int DATA_W = 8;
  localparam int DIV    = 4;
  localparam int CNT_W  = 8;

  logic        clk_8f = 1'b0;
  logic        reset_L = 1'b0;
  logic        enable = 1'b0;
  logic [1:0]  mode = '0;
  logic [7:0]  burst_len = '0;
  logic [7:0]  gap_len = '0;
  logic [15:0] lane_ofs = '0;
  logic [15:0] seed = '0;
  logic        slot_stb;
  logic [1:0]  valid_data;
  logic [15:0] data_in;
  logic [31:0] word_cnt;

  always #5 clk_8f = ~clk_8f;

  phy_tx_pattern_gen #(.LANES(LANES), .DATA_W(DATA_W), .DIV(DIV), .CNT_W(CNT_W)) dut (
    .clk_8f(clk_8f), .reset_L(reset_L), .enable(enable), .mode(mode),
    .burst_len(burst_len), .gap_len(gap_len), .lane_ofs(lane_ofs), .seed(seed),
    .slot_stb(slot_stb), .valid_data(valid_data), .data_in(data_in), .word_cnt(word_cnt)
  );

  typedef struct packed {
    logic [1:0]  v;
    logic [15:0] d;
    logic [31:0] wc;
  } exp_t;

  exp_t q[$];
  int   errors = 0;
  int   checks = 0;

  int         cfg_mode, cfg_burst, cfg_gap;
  int         cfg_ofs[2];
  logic [7:0] cfg_seed[2];

  bit         rec_on = 0;
  logic [7:0] obs0[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [7:0] m_step(input int md, input logic [7:0] d, input logic [7:0] s);
    if (md == 1) return s;
    if (md == 2) return d[0] ? 8'(({1'b0, d} ^ 9'h171) >> 1) : (d >> 1);
    return d + 8'd1;
  endfunction

  // Expected per-slot lane outputs from the burst/gap arithmetic.
  task automatic push_expect(input int n);
    logic [7:0]  md[2];
    logic [15:0] wc[2];
    exp_t        e;
    for (int l = 0; l < 2; l++) begin
      md[l] = (cfg_mode == 2 && cfg_seed[l] == 8'h00) ? 8'h01 : cfg_seed[l];
      wc[l] = 16'h0;
    end
    for (int k = 0; k < n; k++) begin
      for (int l = 0; l < 2; l++) begin
        bit v;
        v = (cfg_burst != 0) && (k >= cfg_ofs[l]) &&
            (((k - cfg_ofs[l]) % (cfg_burst + cfg_gap)) < cfg_burst);
        if (v) begin
          md[l] = m_step(cfg_mode, md[l], cfg_seed[l]);
          if (wc[l] != 16'hFFFF) wc[l] = wc[l] + 16'd1;
        end
        e.v[l]         = v;
        e.d[l*8 +: 8]  = md[l];
        e.wc[l*16 +: 16] = wc[l];
      end
      q.push_back(e);
    end
  endtask

  // Monitor: compares after every edge on which a slot advanced.
  initial begin : monitor
    bit   pending = 0;
    exp_t e;
    forever begin
      @(negedge clk_8f);
      if (!reset_L) begin
        pending = 0;
      end else begin
        if (pending && q.size() > 0) begin
          e = q.pop_front();
          for (int l = 0; l < 2; l++) begin
            check($sformatf("lane%0d_valid", l), 64'(valid_data[l]), 64'(e.v[l]));
            if (e.v[l]) check($sformatf("lane%0d_data", l), 64'(data_in[l*8 +: 8]), 64'(e.d[l*8 +: 8]));
            check($sformatf("lane%0d_word_cnt", l), 64'(word_cnt[l*16 +: 16]), 64'(e.wc[l*16 +: 16]));
          end
          if (rec_on && valid_data[0]) obs0.push_back(data_in[7:0]);
        end
        pending = slot_stb && enable;
      end
    end
  end

  task automatic apply_cfg();
    mode      = 2'(cfg_mode);
    burst_len = 8'(cfg_burst);
    gap_len   = 8'(cfg_gap);
    lane_ofs  = {8'(cfg_ofs[1]), 8'(cfg_ofs[0])};
    seed      = {cfg_seed[1], cfg_seed[0]};
  endtask

  task automatic start_session(input int n, input bit chk_stb);
    apply_cfg();
    @(posedge clk_8f); #2;
    reset_L = 1'b0;
    enable  = 1'b0;
    repeat (2) @(posedge clk_8f);
    #2;
    check("reset_state", {13'h0, slot_stb, valid_data, data_in, word_cnt}, 64'h0);
    q.delete();
    push_expect(n);
    reset_L = 1'b1;
    enable  = 1'b1;
    if (chk_stb) begin
      for (int c = 0; c < 12; c++) begin
        @(negedge clk_8f);
        check($sformatf("slot_stb_cycle%0d", c), 64'(slot_stb), 64'((c % 4) == 3));
      end
    end
  endtask

  task automatic finish_session(input int n);
    int budget;
    budget = n * DIV + 40;
    while (q.size() > 0 && budget > 0) begin
      @(negedge clk_8f);
      budget--;
    end
    checks++;
    if (q.size() > 0) begin
      errors++;
      $display("FAIL session_timeout: got %0d pending slots expected 0", q.size());
    end
    @(posedge clk_8f); #2;
    enable = 1'b0;
  endtask

  task automatic wait_lane0(input int what, input logic [15:0] val, input string name);
    int budget;
    budget = 200;
    while (budget > 0) begin
      @(negedge clk_8f);
      if (what == 0 && valid_data[0] && data_in[7:0] == val[7:0]) break;
      if (what == 1 && word_cnt[15:0] == val) break;
      budget--;
    end
    checks++;
    if (budget == 0) begin
      errors++;
      $display("FAIL %s: got timeout expected lane0 event %0h", name, val);
    end
  endtask

  initial begin : stim
    int  distinct;
    bit  seen[256];

    // INC baseline with offset lane and slot strobe phase
    cfg_mode = 0; cfg_burst = 3; cfg_gap = 3;
    cfg_ofs[0] = 0; cfg_ofs[1] = 1; cfg_seed[0] = 8'h00; cfg_seed[1] = 8'hEF;
    start_session(16, 1'b1);
    finish_session(16);

    // wrap-around, continuous valid
    cfg_mode = 0; cfg_burst = 5; cfg_gap = 0;
    cfg_ofs[0] = 0; cfg_ofs[1] = 2; cfg_seed[0] = 8'hFE; cfg_seed[1] = 8'($urandom);
    start_session(14, 1'b0);
    finish_session(14);

    // LFSR from a zero seed, full period
    cfg_mode = 2; cfg_burst = 200; cfg_gap = 0;
    cfg_ofs[0] = 0; cfg_ofs[1] = 0; cfg_seed[0] = 8'h00; cfg_seed[1] = 8'($urandom_range(1, 255));
    obs0.delete();
    rec_on = 1;
    start_session(260, 1'b0);
    finish_session(260);
    rec_on = 0;
    distinct = 0;
    foreach (seen[i]) seen[i] = 0;
    if (obs0.size() >= 256) begin
      for (int i = 0; i < 255; i++) begin
        if (obs0[i] != 8'h00 && !seen[obs0[i]]) distinct++;
        seen[obs0[i]] = 1;
      end
      check("lfsr_distinct", 64'(distinct), 64'd255);
      check("lfsr_period", 64'(obs0[255]), 64'(obs0[0]));
    end else begin
      check("lfsr_word_count", 64'(obs0.size()), 64'd256);
    end

    // enable freeze mid-burst
    cfg_mode = 0; cfg_burst = 5; cfg_gap = 2;
    cfg_ofs[0] = 0; cfg_ofs[1] = 0; cfg_seed[0] = 8'h00; cfg_seed[1] = 8'h40;
    start_session(10, 1'b0);
    wait_lane0(0, 16'h02, "freeze_wait");
    @(posedge clk_8f); #2;
    enable = 1'b0;
    repeat (10) begin
      @(posedge clk_8f); #1;
      check("freeze_valid", 64'(valid_data), 64'h0);
      check("freeze_stb", 64'(slot_stb), 64'h0);
    end
    #1;
    enable = 1'b1;
    finish_session(10);

    // asynchronous reset mid-burst, then restart with a new seed
    cfg_mode = 0; cfg_burst = 5; cfg_gap = 1;
    cfg_ofs[0] = 0; cfg_ofs[1] = 0; cfg_seed[0] = 8'h00; cfg_seed[1] = 8'h80;
    start_session(12, 1'b0);
    wait_lane0(1, 16'd2, "reset_wait");
    @(posedge clk_8f); #3;
    reset_L = 1'b0;
    #1;
    check("async_reset", {13'h0, slot_stb, valid_data, data_in, word_cnt}, 64'h0);
    q.delete();
    cfg_seed[0] = 8'h10;
    start_session(10, 1'b0);
    finish_session(10);

    // burst 0: never valid
    cfg_mode = 0; cfg_burst = 0; cfg_gap = 3;
    cfg_ofs[0] = 0; cfg_ofs[1] = 2; cfg_seed[0] = 8'h33; cfg_seed[1] = 8'h44;
    start_session(20, 1'b0);
    finish_session(20);

    // CONST payload
    cfg_mode = 1; cfg_burst = 4; cfg_gap = 2;
    cfg_ofs[0] = 1; cfg_ofs[1] = 0; cfg_seed[0] = 8'hA5; cfg_seed[1] = 8'h5A;
    start_session(12, 1'b0);
    finish_session(12);

    // random configs; inputs scrambled after the first slot must be ignored
    for (int r = 0; r < 5; r++) begin
      cfg_mode   = int'($urandom_range(0, 3));
      cfg_burst  = int'($urandom_range(0, 6));
      cfg_gap    = int'($urandom_range(0, 4));
      cfg_ofs[0] = int'($urandom_range(0, 5));
      cfg_ofs[1] = int'($urandom_range(0, 5));
      cfg_seed[0] = 8'($urandom);
      cfg_seed[1] = 8'($urandom);
      start_session(30, 1'b0);
      repeat (2 * DIV + 2) @(posedge clk_8f);
      #2;
      mode      = 2'($urandom);
      burst_len = 8'($urandom);
      gap_len   = 8'($urandom);
      lane_ofs  = 16'($urandom);
      seed      = 16'($urandom);
      finish_session(30);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/phy_tx_pattern_gen.md
# phy_tx_pattern_gen

Synthesizable, parametrised traffic source for the phy_tx lanes. Each lane emits words at the parallel-word rate, on a one-word-slot grid derived from `clk_8f`. Traffic is programmable: per-lane start offset, burst/gap shaping, and increment, constant or LFSR payload. It drives `valid_data`/`data_in` of phy_tx for multi-lane bring-up and in-system BIST, replacing hand-coded stimulus sequences.

## Interface
- `LANES`, 2, number of lanes.
- `DATA_W`, 8, word width (supported: 8, 16, 32).
- `DIV`, 4, `clk_8f` cycles per word slot (≥2).
- `CNT_W`, 8, width of burst/gap/offset counters.

Reset and clocking: one clock (`clk_8f`); reset (`reset_L`) is asynchronous and active-low.

- `clk_8f`  in  1  sole clock.
- `reset_L`  in  1  asynchronous active-low reset.
- `enable`  in  1  run/freeze.
- `mode`  in  2  0=INC, 1=CONST, 2=LFSR, 3=reserved (treated as INC).
- `burst_len`  in  CNT_W  valid slots per burst.
- `gap_len`  in  CNT_W  idle slots between bursts.
- `lane_ofs`  in  LANES*CNT_W  idle slots before first burst, per lane.
- `seed`  in  LANES*DATA_W  initial data, per lane.
- `slot_stb`  out  1  one-cycle pulse marking a slot boundary.
- `valid_data`  out  LANES  per-lane valid.
- `data_in`  out  LANES*DATA_W  per-lane word (lane i at bits [i*DATA_W +: DATA_W]).
- `word_cnt`  out  LANES*16  valid words sent per lane, saturating at 16'hFFFF.

## Operation
- Slot counter runs 0..DIV-1 while `enable`=1 and wraps. `slot_stb`=1 when counter==DIV-1. Lane state and outputs advance only on `slot_stb`.
- Config sampling: `mode`, `burst_len`, `gap_len`, `lane_ofs` and `seed` are latched on the first `slot_stb` after reset (IDLE→START). Later input changes are ignored until the next reset.
- Per-lane FSM:
  - IDLE→OFFSET on first slot.
  - OFFSET counts `lane_ofs` slots (0 ⇒ straight to BURST on that same slot).
  - BURST: `valid_data`=1 for `burst_len` slots, then GAP.
  - GAP: `valid_data`=0 for `gap_len` slots, then BURST.
  - `gap_len`=0 ⇒ continuous valid.
  - `burst_len`=0 ⇒ lane never asserts valid (loops in GAP).
- Data updates only on valid slots:
  - INC: data+1, modulo 2^DATA_W.
  - CONST: seed.
  - LFSR: Galois step, taps from package.
- Data register is loaded with seed at START, so the first valid word is seed+1 (INC), seed (CONST), or lfsr(seed) (LFSR). A zero seed in LFSR mode is replaced by 1.
- During GAP/OFFSET, `data_in` holds the last value.
- `word_cnt[i]` increments on each slot where lane i is valid, and saturates.
- `enable` low: slot counter, FSMs and data freeze. On the next clock, `valid_data` is forced to 0 and `slot_stb` stays 0. On `enable` high, operation resumes at the frozen state; slot phase restarts from the frozen counter value.

## Timing
- All outputs are registered. Reset value of every output, counter and data register is 0. FSMs reset to IDLE.
- After `enable` rises with counter at 0, `slot_stb` is high in cycles 3, 7, 11, … (DIV=4).
- Lane outputs change on the clock edge where `slot_stb`=1. They are visible the following cycle and stable for DIV cycles.
- Latency from first `slot_stb` to first `valid_data` of lane i: `lane_ofs[i]` slots, plus the registered edge.
- Reset asserted mid-burst: outputs go to 0 immediately (asynchronous). After release, the block restarts from IDLE and re-samples config.

## Structure
- Package `phy_tx_pkg` holds:
  - mode localparams `MODE_INC`/`MODE_CONST`/`MODE_LFSR`;
  - FSM state encoding;
  - function `lfsr_next(data, width)`, with taps 8:{8,6,5,4}, 16:{16,15,13,4}, 32:{32,22,2,1}.
- Sub-module `lane_seq`: one lane's FSM, counters, data register and `word_cnt`. The top instantiates LANES copies via generate and owns only the slot counter and the enable gating.

## Test plan
- INC baseline (LANES=2, DIV=4): seed {EF,00}, burst 3, gap 3, ofs {0,1} → lane0 valid 01,02,03, 3 idle slots, 04…; lane1 starts one slot later with F0,F1,F2.
- Wrap and continuous: INC, seed FE, gap 0, burst 5 → FF,00,01,02,03,04… with valid never dropping; `word_cnt` tracks the count.
- LFSR: mode 2, seed 00 → first word lfsr_next(01); 255 distinct nonzero words before repeat (DATA_W=8).
- Enable freeze: drop `enable` mid-burst after word 02 for 10 cycles → `valid_data`=0 next cycle, no `slot_stb`; on re-enable the next valid word is 03.
- Reset mid-burst: assert `reset_L`=0 asynchronously between edges → all outputs 0 at once; after release with new seed 10, first word is 11.
- Degenerate config: burst 0 → `valid_data` stays 0 and `word_cnt` stays 0 across 20 slots; CONST mode, seed A5 → every valid word A5.
